// File: rtl/irq_dispatch.sv
// Interrupt dispatch sequencer: edge-latches masked request lines and picks the
// highest-priority eligible line. It runs the redirect handshake and keeps a
// nesting stack of return addresses.
module irq_dispatch #(
   parameter int unsigned NUM_IRQ       = 3,
   parameter logic [31:0] VECTOR_BASE   = 32'h0000_0800,
   parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_IRQ-1:0]             irq_in,
   input  logic [NUM_IRQ-1:0]             irq_clear,
   input  logic                           can_take,
   input  logic [31:0]                    pc_current,
   input  logic                           take_ack,
   input  logic                           eret,
   output logic                           take_req,
   output logic [31:0]                    vector_pc,
   output logic [31:0]                    epc_out,
   output logic [NUM_IRQ-1:0]             in_service,
   output logic [$clog2(NUM_IRQ+1)-1:0]   nest_level,
   output logic [NUM_IRQ-1:0]             pending
);

   localparam int unsigned LW = $clog2(NUM_IRQ + 1);
   localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t               state, state_nxt;
   logic [NUM_IRQ-1:0]   irq_prev;
   logic [NUM_IRQ-1:0]   rise;
   logic [NUM_IRQ-1:0]   eligible;
   logic [NUM_IRQ-1:0]   top_service;
   logic [NUM_IRQ-1:0]   win_mask;
   logic [IW-1:0]        winner;
   logic [IW-1:0]        win_idx;
   logic [31:0]          win_pc;
   logic [31:0]          stack [NUM_IRQ];
   logic                 start;
   logic                 do_push;
   logic                 do_pop;
   logic                 blocked;

   always_comb rise = irq_in & ~irq_prev;

   // Scan from the top: the first in-service line blocks itself and everything below.
   always_comb begin
      blocked     = 1'b0;
      eligible    = '0;
      top_service = '0;
      winner      = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++) begin
         if (!blocked && in_service[NUM_IRQ-1-k])
            top_service[NUM_IRQ-1-k] = 1'b1;
         blocked = blocked | in_service[NUM_IRQ-1-k];
         eligible[NUM_IRQ-1-k] = pending[NUM_IRQ-1-k] & ~blocked;
      end
      for (int unsigned i = 0; i < NUM_IRQ; i++)
         if (eligible[i])
            winner = IW'(i);
   end

   always_comb begin
      win_mask = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++)
         win_mask[i] = (win_idx == IW'(i));
   end

   always_comb begin
      start   = (state == IDLE) && (|eligible) && can_take;
      do_push = (state == REQ) && take_ack;
      do_pop  = eret && (nest_level != '0) && !do_push;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = REQ;
         REQ:  if (take_ack || eret) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      take_req  = (state == REQ);
      vector_pc = '0;
      if (state == REQ)
         vector_pc = VECTOR_BASE + VECTOR_STRIDE * 32'(win_idx);
   end

   always_comb begin
      epc_out = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++)
         if (nest_level == LW'(i + 1))
            epc_out = stack[i];
   end

   // A fresh rising edge re-sets a pending bit even when the ack or a clear drops it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_prev   <= '0;
         pending    <= '0;
         in_service <= '0;
         nest_level <= '0;
         win_idx    <= '0;
         win_pc     <= '0;
         for (int unsigned i = 0; i < NUM_IRQ; i++)
            stack[i] <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~irq_clear & ~(do_push ? win_mask : '0)) | rise;
         if (start) begin
            win_idx <= winner;
            win_pc  <= pc_current;
         end
         if (do_push) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++)
               if (nest_level == LW'(i))
                  stack[i] <= win_pc;
            in_service <= in_service | win_mask;
            nest_level <= nest_level + LW'(1);
         end else if (do_pop) begin
            in_service <= in_service & ~top_service;
            nest_level <= nest_level - LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch; each task drives one scenario and checks inline
// against hand-computed values.
module tb_irq_dispatch;

   logic        clock;
   logic        reset;
   logic [2:0]  irq_in;
   logic [2:0]  irq_clear;
   logic        can_take;
   logic [31:0] pc_current;
   logic        take_ack;
   logic        eret;
   logic        take_req;
   logic [31:0] vector_pc;
   logic [31:0] epc_out;
   logic [2:0]  in_service;
   logic [1:0]  nest_level;
   logic [2:0]  pending;

   int passed = 0;
   int total  = 0;

   irq_dispatch #(
      .NUM_IRQ(3),
      .VECTOR_BASE(32'h0000_0800),
      .VECTOR_STRIDE(32'h0000_0010)
   ) dut (
      .clock(clock), .reset(reset), .irq_in(irq_in), .irq_clear(irq_clear),
      .can_take(can_take), .pc_current(pc_current), .take_ack(take_ack), .eret(eret),
      .take_req(take_req), .vector_pc(vector_pc), .epc_out(epc_out),
      .in_service(in_service), .nest_level(nest_level), .pending(pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      irq_in = '0; irq_clear = '0; can_take = 0; pc_current = '0; take_ack = 0; eret = 0;
      reset = 0;
      #2;
      reset = 1;
      cycle();
   endtask

   task automatic test_reset();
      irq_in = '0; irq_clear = '0; can_take = 0; pc_current = '0; take_ack = 0; eret = 0;
      reset = 0;
      #2;
      total++; if (take_req !== 1'b0) $display("FAIL reset_take_req got %0b exp 0", take_req); else passed++;
      total++; if (vector_pc !== 32'h0) $display("FAIL reset_vector got %h exp 0", vector_pc); else passed++;
      total++; if (epc_out !== 32'h0) $display("FAIL reset_epc got %h exp 0", epc_out); else passed++;
      total++; if ({in_service, nest_level, pending} !== 8'h0) $display("FAIL reset_state got %b exp 0", {in_service, nest_level, pending}); else passed++;
      reset = 1;
      cycle();
   endtask

   task automatic test_single();
      do_reset();
      irq_in = 3'b001; can_take = 1; pc_current = 32'h100;
      cycle();
      total++; if (pending !== 3'b001) $display("FAIL single_pending got %b exp 001", pending); else passed++;
      total++; if (take_req !== 1'b0) $display("FAIL single_early_req got %0b exp 0", take_req); else passed++;
      cycle();
      total++; if (take_req !== 1'b1) $display("FAIL single_req got %0b exp 1", take_req); else passed++;
      total++; if (vector_pc !== 32'h800) $display("FAIL single_vector got %h exp 800", vector_pc); else passed++;
      take_ack = 1;
      cycle();
      take_ack = 0;
      total++; if (take_req !== 1'b0) $display("FAIL single_req_drop got %0b exp 0", take_req); else passed++;
      total++; if (in_service !== 3'b001) $display("FAIL single_in_service got %b exp 001", in_service); else passed++;
      total++; if (epc_out !== 32'h100) $display("FAIL single_epc got %h exp 100", epc_out); else passed++;
      total++; if (nest_level !== 2'd1) $display("FAIL single_nest got %0d exp 1", nest_level); else passed++;
      total++; if (pending !== 3'b000) $display("FAIL single_pending_clr got %b exp 000", pending); else passed++;
      total++; if (vector_pc !== 32'h0) $display("FAIL single_vector_idle got %h exp 0", vector_pc); else passed++;
      eret = 1;
      cycle();
      eret = 0;
      total++; if ({in_service, nest_level} !== 5'b0) $display("FAIL single_eret_pop got %b exp 0", {in_service, nest_level}); else passed++;
      total++; if (epc_out !== 32'h0) $display("FAIL single_eret_epc got %h exp 0", epc_out); else passed++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      irq_in = 3'b101; can_take = 1; pc_current = 32'h100;
      cycle();
      total++; if (pending !== 3'b101) $display("FAIL simul_pending got %b exp 101", pending); else passed++;
      cycle();
      total++; if (vector_pc !== 32'h820) $display("FAIL simul_vector2 got %h exp 820", vector_pc); else passed++;
      take_ack = 1;
      cycle();
      take_ack = 0;
      total++; if (in_service !== 3'b100) $display("FAIL simul_in_service got %b exp 100", in_service); else passed++;
      total++; if (pending !== 3'b001) $display("FAIL simul_pending_left got %b exp 001", pending); else passed++;
      eret = 1;
      cycle();
      eret = 0;
      total++; if (take_req !== 1'b0) $display("FAIL simul_req_at_eret got %0b exp 0", take_req); else passed++;
      total++; if (nest_level !== 2'd0) $display("FAIL simul_nest got %0d exp 0", nest_level); else passed++;
      cycle();
      total++; if (take_req !== 1'b1) $display("FAIL simul_req0 got %0b exp 1", take_req); else passed++;
      total++; if (vector_pc !== 32'h800) $display("FAIL simul_vector0 got %h exp 800", vector_pc); else passed++;
   endtask

   task automatic test_preempt();
      do_reset();
      irq_in = 3'b001; can_take = 1; pc_current = 32'h100;
      cycle();
      cycle();
      take_ack = 1;
      cycle();
      take_ack = 0;
      pc_current = 32'h200; irq_in = 3'b011;
      cycle();
      total++; if (pending !== 3'b010) $display("FAIL preempt_pending got %b exp 010", pending); else passed++;
      cycle();
      total++; if (vector_pc !== 32'h810) $display("FAIL preempt_vector got %h exp 810", vector_pc); else passed++;
      take_ack = 1;
      cycle();
      take_ack = 0;
      total++; if (nest_level !== 2'd2) $display("FAIL preempt_nest got %0d exp 2", nest_level); else passed++;
      total++; if (epc_out !== 32'h200) $display("FAIL preempt_epc got %h exp 200", epc_out); else passed++;
      total++; if (in_service !== 3'b011) $display("FAIL preempt_in_service got %b exp 011", in_service); else passed++;
      irq_in = 3'b010;
      cycle();
      irq_in = 3'b011;
      cycle();
      total++; if (pending !== 3'b001) $display("FAIL preempt_low_pending got %b exp 001", pending); else passed++;
      cycle();
      total++; if (take_req !== 1'b0) $display("FAIL preempt_low_blocked got %0b exp 0", take_req); else passed++;
      eret = 1;
      cycle();
      eret = 0;
      total++; if (in_service !== 3'b001) $display("FAIL preempt_eret_svc got %b exp 001", in_service); else passed++;
      total++; if (epc_out !== 32'h100) $display("FAIL preempt_eret_epc got %h exp 100", epc_out); else passed++;
      cycle();
      total++; if (take_req !== 1'b0) $display("FAIL preempt_self_blocked got %0b exp 0", take_req); else passed++;
   endtask

   task automatic test_hold_withdraw();
      do_reset();
      irq_in = 3'b001; can_take = 1; pc_current = 32'h100;
      cycle();
      cycle();
      take_ack = 1;
      cycle();
      take_ack = 0;
      irq_in = 3'b011;
      cycle();
      cycle();
      for (int unsigned i = 0; i < 5; i++) begin
         can_take = 0;
         pc_current = 32'h1000 + 32'(i);
         cycle();
         total++; if (take_req !== 1'b1 || vector_pc !== 32'h810) $display("FAIL hold_req got %0b/%h exp 1/810", take_req, vector_pc); else passed++;
         total++; if (nest_level !== 2'd1 || epc_out !== 32'h100) $display("FAIL hold_no_push got %0d/%h exp 1/100", nest_level, epc_out); else passed++;
      end
      eret = 1;
      cycle();
      eret = 0; can_take = 1;
      total++; if (take_req !== 1'b0) $display("FAIL withdraw_req got %0b exp 0", take_req); else passed++;
      total++; if (nest_level !== 2'd0 || in_service !== 3'b000) $display("FAIL withdraw_pop got %0d/%b exp 0/000", nest_level, in_service); else passed++;
      total++; if (pending !== 3'b010) $display("FAIL withdraw_pending got %b exp 010", pending); else passed++;
      cycle();
      total++; if (take_req !== 1'b1 || vector_pc !== 32'h810) $display("FAIL withdraw_reraise got %0b/%h exp 1/810", take_req, vector_pc); else passed++;
   endtask

   task automatic test_race_idle_eret();
      do_reset();
      irq_in = 3'b010;
      cycle();
      irq_in = 3'b000;
      cycle();
      irq_in = 3'b010; irq_clear = 3'b010;
      cycle();
      total++; if (pending !== 3'b010) $display("FAIL race_set_wins got %b exp 010", pending); else passed++;
      cycle();
      irq_clear = 3'b000;
      total++; if (pending !== 3'b000) $display("FAIL race_clear got %b exp 000", pending); else passed++;
      eret = 1;
      cycle();
      eret = 0;
      total++; if ({take_req, in_service, nest_level, pending} !== 9'b0) $display("FAIL idle_eret got %b exp 0", {take_req, in_service, nest_level, pending}); else passed++;
      total++; if (epc_out !== 32'h0) $display("FAIL idle_eret_epc got %h exp 0", epc_out); else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      irq_in = 3'b001; can_take = 1; pc_current = 32'h100;
      cycle();
      cycle();
      irq_in = 3'b101; take_ack = 1; eret = 1;
      cycle();
      take_ack = 0; eret = 0;
      total++; if (take_req !== 1'b0) $display("FAIL b2b_bubble got %0b exp 0", take_req); else passed++;
      total++; if (nest_level !== 2'd1 || in_service !== 3'b001) $display("FAIL b2b_ack_wins got %0d/%b exp 1/001", nest_level, in_service); else passed++;
      total++; if (pending !== 3'b100) $display("FAIL b2b_pending got %b exp 100", pending); else passed++;
      cycle();
      total++; if (take_req !== 1'b1 || vector_pc !== 32'h820) $display("FAIL b2b_reraise got %0b/%h exp 1/820", take_req, vector_pc); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      irq_in = 3'b001; can_take = 1; pc_current = 32'h100;
      cycle();
      cycle();
      take_ack = 1;
      cycle();
      take_ack = 0;
      irq_in = 3'b011;
      cycle();
      cycle();
      total++; if (take_req !== 1'b1) $display("FAIL mid_req_up got %0b exp 1", take_req); else passed++;
      #2;
      reset = 0;
      #1;
      total++; if (take_req !== 1'b0 || vector_pc !== 32'h0) $display("FAIL mid_reset_req got %0b/%h exp 0/0", take_req, vector_pc); else passed++;
      total++; if (epc_out !== 32'h0 || {in_service, nest_level, pending} !== 8'h0) $display("FAIL mid_reset_state got %h/%b exp 0/0", epc_out, {in_service, nest_level, pending}); else passed++;
      #2;
      reset = 1;
      cycle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_preempt();
      test_hold_withdraw();
      test_race_idle_eret();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/irq_dispatch.md
# irq_dispatch

Interrupt dispatch sequencer on the far side of the CP0 interrupt block. It consumes the IE-masked request lines, edge-latches them into pending bits, and selects the highest-priority eligible request. It then runs a request/acknowledge handshake with the pipeline to redirect fetch to a per-line vector, and keeps a nesting stack of return addresses that `eret` unwinds.

## Interface
- `NUM_IRQ`, 3, number of request lines; also the nesting stack depth.
- `VECTOR_BASE`, 32'h0000_0800, handler address for line 0.
- `VECTOR_STRIDE`, 32'h0000_0010, address spacing between consecutive line handlers.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_in`  in  NUM_IRQ  masked request lines (the IRout of the CP0 interrupt block), level signals.
- `irq_clear`  in  NUM_IRQ  per-line software acknowledge pulses; each clears the matching pending bit.
- `can_take`  in  1  pipeline is at an interruptible instruction boundary.
- `pc_current`  in  32  resume address saved when a request is accepted.
- `take_ack`  in  1  pipeline accepts the redirect.
- `eret`  in  1  one-cycle return pulse from the pipeline.
- `take_req`  out  1  redirect request.
- `vector_pc`  out  32  handler address for the request being presented.
- `epc_out`  out  32  top-of-stack return address; 0 when the stack is empty.
- `in_service`  out  NUM_IRQ  lines whose handler is active.
- `nest_level`  out  $clog2(NUM_IRQ+1)  stack occupancy.
- `pending`  out  NUM_IRQ  latched pending bits.

## Operation
- **Edge capture.** Register `irq_prev` samples `irq_in`. A rising edge is `irq_in & ~irq_prev`; it sets the matching `pending` bit.
  - If set and `irq_clear` hit the same bit in the same cycle, set wins.
  - `irq_prev` resets to 0, so a line already high when reset releases counts as an edge.
- **Priority.** A higher index means higher priority.
  - `threshold` is the index of the highest `in_service` bit, or -1 when nothing is in service.
  - `eligible` = the pending bits whose index is above `threshold`. A line already in service, or any lower-priority line, cannot preempt.
  - `winner` = the highest set bit of `eligible`.
- **FSM states: IDLE, REQ.**
  - IDLE → REQ when `eligible` is non-zero and `can_take`=1. On that transition, latch `win_idx`=`winner` and `win_pc`=`pc_current`.
  - REQ drives `take_req`=1 and `vector_pc` = VECTOR_BASE + `win_idx`*VECTOR_STRIDE (mod 2^32). Both stay constant until the state leaves REQ.
  - REQ + `take_ack`=1 → IDLE, with these effects in the same edge:
    - push `win_pc`;
    - set `in_service[win_idx]`;
    - clear `pending[win_idx]`, unless a new rising edge on that line arrives the same cycle, in which case it stays set;
    - `nest_level`++.
  - REQ + `eret`=1 + `take_ack`=0: withdraw the request. Return to IDLE with no push, then perform the pop below.
  - REQ + `eret`=1 + `take_ack`=1 is a protocol violation. The ack is processed and `eret` is dropped.
  - In REQ, `can_take` falling does not cancel the request.
- **eret pop.** Processed in IDLE, or in REQ as described above.
  - Clear the highest `in_service` bit, pop the stack, and `nest_level`--.
  - With `nest_level`=0, `eret` is ignored.
- **Stack.** Depth NUM_IRQ. It cannot overflow, because each line is in service at most once. `epc_out` is combinational from the top entry.
- `vector_pc` = 0 outside REQ.

## Timing
- **Reset.** On `reset`=0, asynchronously: `take_req`=0, `vector_pc`=0, `epc_out`=0, `in_service`=0, `nest_level`=0, `pending`=0, `irq_prev`=0, stack cleared, state IDLE.
- **Latency.** Rising edge of `irq_in` sampled at edge n → `pending` set after n → `take_req`=1 after edge n+1, provided `can_take`=1 during cycle n+1. Minimum 2 cycles from edge to request.
- **Handshake.** `take_ack` is honoured only while `take_req`=1. `take_req` drops the cycle after the accepting edge.
  - Back-to-back: a higher-priority pending line can re-raise `take_req` one cycle after ack, giving a one-cycle bubble.
- **eret.** `in_service`, `nest_level` and `epc_out` update at the edge that samples `eret`. The next request can be raised one cycle after that edge.
- **Reset mid-handshake.** The request is dropped immediately and no push occurs.

## Test plan
- **Single request.** Reset, then `irq_in`=3'b001 with `can_take`=1 and `pc_current`=32'h100 → `take_req` high 2 cycles after the edge with `vector_pc`=32'h800. Then ack → `in_service`=001, `epc_out`=32'h100, `nest_level`=1, `pending`=000.
- **Simultaneous lines.** `irq_in` rises 000→101 → `vector_pc`=32'h820 for line 2. After ack and `eret`, line 0 is dispatched to 32'h800.
- **Preemption.** With line 0 in service and `pc_current`=32'h200, line 1 rises → dispatch to 32'h810, `nest_level`=2, `epc_out`=32'h200. With line 1 in service, a line 0 edge stays pending and is not requested.
- **Hold and withdraw.** Hold REQ with no ack for 5 cycles while `pc_current` changes → `vector_pc` is stable and no push occurs. Then `eret` without ack (with `nest_level`=1) → `take_req` drops the next cycle and `nest_level`=0.
- **Pending race and idle eret.** `irq_clear` and a rising edge on the same line in the same cycle → `pending` stays 1. `eret` at `nest_level`=0 → no state change.
- **Reset during REQ.** Assert `reset`=0 while `take_req`=1 → all outputs 0 asynchronously, without waiting for a clock edge.
